time_set_controller: RTL

//  Front-panel sequencer for the clock/calendar datapath. Turns two raw push-buttons (MODE, UP)

---
 rtl/time_set_controller_pkg.sv | 59 +++++
 rtl/time_set_controller_button_conditioner.sv | 62 ++++++
 rtl/time_set_controller.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/time_set_controller_pkg.sv
// Shared encodings for the front-panel time-set controller: edit states double as field_sel codes.
// The VGA renderer decodes the same FS_* values to choose which field blinks.
package time_set_controller_pkg;

    localparam logic [2:0] FS_NONE  = 3'd0;
    localparam logic [2:0] FS_HR    = 3'd1;
    localparam logic [2:0] FS_MIN   = 3'd2;
    localparam logic [2:0] FS_AMPM  = 3'd3;
    localparam logic [2:0] FS_MONTH = 3'd4;
    localparam logic [2:0] FS_DAY   = 3'd5;
    localparam logic [2:0] FS_YEAR  = 3'd6;
    localparam logic [2:0] FS_CENT  = 3'd7;

    typedef enum logic [2:0] {
        ST_RUN        = FS_NONE,
        ST_EDIT_HR    = FS_HR,
        ST_EDIT_MIN   = FS_MIN,
        ST_EDIT_AMPM  = FS_AMPM,
        ST_EDIT_MONTH = FS_MONTH,
        ST_EDIT_DAY   = FS_DAY,
        ST_EDIT_YEAR  = FS_YEAR,
        ST_EDIT_CENT  = FS_CENT
    } state_e;

    // Bit order: {cent, year, day, month, am_pm, min, hr}
    function automatic logic [6:0] field_strobe(input state_e st);
        logic [6:0] s;
        s = 7'd0;
        case (st)
            ST_EDIT_HR:    s = 7'b000_0001;
            ST_EDIT_MIN:   s = 7'b000_0010;
            ST_EDIT_AMPM:  s = 7'b000_0100;
            ST_EDIT_MONTH: s = 7'b000_1000;
            ST_EDIT_DAY:   s = 7'b001_0000;
            ST_EDIT_YEAR:  s = 7'b010_0000;
            ST_EDIT_CENT:  s = 7'b100_0000;
            default:       s = 7'd0;
        endcase
        return s;
    endfunction

    function automatic state_e next_field(input state_e st);
        state_e n;
        n = ST_RUN;
        case (st)
            ST_RUN:        n = ST_EDIT_HR;
            ST_EDIT_HR:    n = ST_EDIT_MIN;
            ST_EDIT_MIN:   n = ST_EDIT_AMPM;
            ST_EDIT_AMPM:  n = ST_EDIT_MONTH;
            ST_EDIT_MONTH: n = ST_EDIT_DAY;
            ST_EDIT_DAY:   n = ST_EDIT_YEAR;
            ST_EDIT_YEAR:  n = ST_EDIT_CENT;
            ST_EDIT_CENT:  n = ST_RUN;
            default:       n = ST_RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/time_set_controller_button_conditioner.sv
// button_conditioner: 2-FF synchronizer, debounce counter and one-cycle rise pulse for a raw button.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          rise_q;
    logic          rise_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The accepted level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = CNT_ZERO;
        if (sync2_q != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                cnt_d   = CNT_ZERO;
            end else begin
                cnt_d   = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = CNT_ZERO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= CNT_ZERO;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: MODE/UP front-panel edit FSM producing one-cycle inc_* strobes and field_sel.
// Optional build macro AUTO_REPEAT_EN enables hold-to-repeat on the UP button.
module time_set_controller
    import time_set_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int TIMEOUT_CYCLES  = 1_000_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       set_am_pm,
    output logic       inc_month,
    output logic       inc_day,
    output logic       inc_year,
    output logic       inc_cent,
    output logic       edit_active,
    output logic [2:0] field_sel
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TO_ONE  = TW'(1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          mode_level_s;
    logic          mode_rise_s;
    logic          up_level_s;
    logic          up_rise_s;
    logic          up_press_s;
    logic          rep_fire_s;
    logic          activity_s;
    logic          timeout_s;
    logic          unused_s;
    state_e        state_q;
    state_e        state_d;
    logic [TW-1:0] to_q;
    logic [TW-1:0] to_d;
    logic [6:0]    strobe_q;
    logic [6:0]    strobe_d;
    logic          edit_active_q;
    logic          edit_active_d;
    logic [2:0]    field_sel_q;
    logic [2:0]    field_sel_d;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk     (clk_100MHz),
        .rst_n   (reset_n),
        .btn_raw (btn_mode),
        .level   (mode_level_s),
        .rise    (mode_rise_s)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_btn (
        .clk     (clk_100MHz),
        .rst_n   (reset_n),
        .btn_raw (btn_up),
        .level   (up_level_s),
        .rise    (up_rise_s)
    );

    // MODE wins a same-cycle tie; UP is meaningless outside edit mode.
    always_comb begin
        up_press_s = up_rise_s & ~mode_rise_s & (state_q != ST_RUN);
        activity_s = mode_rise_s | up_rise_s | rep_fire_s;
        timeout_s  = (state_q != ST_RUN) && (to_q >= TO_LAST) && !activity_s;
    end

`ifdef AUTO_REPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int PW = $clog2(REPEAT_PERIOD + 1);
    localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY);
    localparam logic [PW-1:0] PER_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PER_ONE   = PW'(1);
    localparam logic [PW-1:0] PER_LAST  = PW'(REPEAT_PERIOD);

    logic          armed_q;
    logic          armed_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic [PW-1:0] per_q;
    logic [PW-1:0] per_d;

    // hold_q counts cycles since the press; per_q paces strobes once the delay has elapsed.
    always_comb begin
        rep_fire_s = 1'b0;
        if (armed_q && up_level_s && !mode_rise_s && (state_q != ST_RUN) && (hold_q == HOLD_LAST)) begin
            if ((per_q == PER_ZERO) || (per_q == PER_LAST)) begin
                rep_fire_s = 1'b1;
            end else begin
                rep_fire_s = 1'b0;
            end
        end else begin
            rep_fire_s = 1'b0;
        end
    end

    always_comb begin
        armed_d = armed_q;
        hold_d  = hold_q;
        per_d   = per_q;
        if (up_press_s) begin
            armed_d = 1'b1;
            hold_d  = HOLD_ONE;
            per_d   = PER_ZERO;
        end else if (!armed_q || !up_level_s || mode_rise_s || timeout_s) begin
            armed_d = 1'b0;
            hold_d  = HOLD_ZERO;
            per_d   = PER_ZERO;
        end else if (hold_q < HOLD_LAST) begin
            hold_d  = hold_q + HOLD_ONE;
        end else if (rep_fire_s) begin
            per_d   = PER_ONE;
        end else if (per_q < PER_LAST) begin
            per_d   = per_q + PER_ONE;
        end else begin
            per_d   = per_q;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
            hold_q  <= HOLD_ZERO;
            per_q   <= PER_ZERO;
        end else begin
            armed_q <= armed_d;
            hold_q  <= hold_d;
            per_q   <= per_d;
        end
    end

    assign unused_s = mode_level_s;
`else
    assign rep_fire_s = 1'b0;
    assign unused_s   = ^{mode_level_s, up_level_s, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

    // Next-state: a MODE press advances; otherwise an expired timeout drops back to RUN.
    always_comb begin
        state_d = state_q;
        if (mode_rise_s) begin
            state_d = next_field(state_q);
        end else if (timeout_s) begin
            state_d = ST_RUN;
        end else begin
            state_d = state_q;
        end
    end

    always_comb begin
        to_d = to_q;
        if ((state_q == ST_RUN) || (state_d == ST_RUN) || activity_s) begin
            to_d = TO_ZERO;
        end else if (to_q < TO_LAST) begin
            to_d = to_q + TO_ONE;
        end else begin
            to_d = to_q;
        end
    end

    always_comb begin
        strobe_d      = 7'd0;
        edit_active_d = (state_d != ST_RUN);
        field_sel_d   = state_d;
        if (up_press_s || rep_fire_s) begin
            strobe_d = field_strobe(state_q);
        end else begin
            strobe_d = 7'd0;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            to_q          <= TO_ZERO;
            strobe_q      <= 7'd0;
            edit_active_q <= 1'b0;
            field_sel_q   <= FS_NONE;
        end else begin
            to_q          <= to_d;
            strobe_q      <= strobe_d;
            edit_active_q <= edit_active_d;
            field_sel_q   <= field_sel_d;
        end
    end

    assign inc_hr      = strobe_q[0];
    assign inc_min     = strobe_q[1];
    assign set_am_pm   = strobe_q[2];
    assign inc_month   = strobe_q[3];
    assign inc_day     = strobe_q[4];
    assign inc_year    = strobe_q[5];
    assign inc_cent    = strobe_q[6];
    assign edit_active = edit_active_q;
    assign field_sel   = field_sel_q;

endmodule
